// File: rtl/proximity_sequencer.sv
// -----------------------------------------------------------------------------
// proximity_sequencer
//
// Pulses an IR emitter once every PERIOD clocks, samples the (asynchronous)
// sensor output SETTLE cycles into each burst, and debounces the samples
// into a stable object-present flag.
//
// Parameters
//   PERIOD    clocks between successive emitter bursts (4 .. 2^20)
//   SETTLE    emitter-on cycles before the sample is taken (1 .. PERIOD-2)
//   DEBOUNCE  consecutive disagreeing samples needed to flip proximity (1 .. 255)
//
// Ports
//   clk            single clock, rising edge
//   reset_n        asynchronous active-low reset
//   enable         runs the burst/sample sequence while high
//   proximity_out  raw IR sensor output, asynchronous to clk
//   emitter_en     IR emitter drive (registered)
//   proximity      debounced object-present flag
//   detect_pulse   one-cycle pulse on a 0->1 proximity change
//   release_pulse  one-cycle pulse on a 1->0 proximity change
//   sample_valid   one-cycle pulse after every completed sample
//   LED2           proximity delayed by one register stage
// -----------------------------------------------------------------------------
module proximity_sequencer #(
  parameter int PERIOD   = 50000,
  parameter int SETTLE   = 100,
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic proximity_out,
  output logic emitter_en,
  output logic proximity,
  output logic detect_pulse,
  output logic release_pulse,
  output logic sample_valid,
  output logic LED2
);

  // The period counter only ever holds 0 .. PERIOD-1 and the debounce
  // counter 0 .. DEBOUNCE-1, so neither can wrap.
  localparam int CNT_W = $clog2(PERIOD);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;

  logic sync_meta, sync_q;

  logic emitter_d;
  logic proximity_d;
  logic detect_d;
  logic release_d;
  logic sample_valid_d;
  logic sample_now;

  // ---------------------------------------------------------------------------
  // State register (plus the two counters that pace it)
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      db_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default to every output first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      // Dropping enable abandons the sequence immediately, mid-sample or not.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   state_d = ST_SETTLE;
        ST_SETTLE: if (period_cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
        ST_SAMPLE: state_d = ST_WAIT;
        ST_WAIT:   if (period_cnt_q == PERIOD_LAST) state_d = ST_SETTLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // The counter restarts at 0 on every SETTLE entry (from IDLE or WAIT) and
  // is parked at 0 in IDLE, so each period spans counts 0 .. PERIOD-1.
  always_comb begin
    period_cnt_d = period_cnt_q + CNT_W'(1);
    if (state_d == ST_IDLE) begin
      period_cnt_d = '0;
    end else if (state_d == ST_SETTLE && state_q != ST_SETTLE) begin
      period_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  // The sample is only committed if enable is still high on the SAMPLE edge.
  assign sample_now = (state_q == ST_SAMPLE) && enable;

  always_comb begin
    emitter_d      = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    db_cnt_d       = db_cnt_q;
    proximity_d    = proximity;
    detect_d       = 1'b0;
    release_d      = 1'b0;
    sample_valid_d = 1'b0;

    if (state_d == ST_IDLE) begin
      db_cnt_d = '0;
    end else if (sample_now) begin
      sample_valid_d = 1'b1;
      if (sync_q == proximity) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        // This disagreeing sample completes the run: flip the flag.
        db_cnt_d    = '0;
        proximity_d = sync_q;
        detect_d    = sync_q;
        release_d   = ~sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and sensor synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta     <= 1'b0;
      sync_q        <= 1'b0;
      emitter_en    <= 1'b0;
      proximity     <= 1'b0;
      detect_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      sample_valid  <= 1'b0;
      LED2          <= 1'b0;
    end else begin
      sync_meta     <= proximity_out;
      sync_q        <= sync_meta;
      emitter_en    <= emitter_d;
      proximity     <= proximity_d;
      detect_pulse  <= detect_d;
      release_pulse <= release_d;
      sample_valid  <= sample_valid_d;
      LED2          <= proximity;
    end
  end

endmodule

// File: tb/tb_proximity_sequencer.sv
// -----------------------------------------------------------------------------
// tb_proximity_sequencer
//
// Self-checking bench for proximity_sequencer with PERIOD=20, SETTLE=3,
// DEBOUNCE=2. A behavioural model (burst position within the period, sample
// slot, run length of disagreeing samples) is stepped every clock and
// compared with all outputs; a table of per-sample vectors and a few
// hand-written sequences cover the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_proximity_sequencer;

  localparam int PERIOD   = 20;
  localparam int SETTLE   = 3;
  localparam int DEBOUNCE = 2;

  logic clk;
  logic reset_n;
  logic enable;
  logic proximity_out;
  logic emitter_en;
  logic proximity;
  logic detect_pulse;
  logic release_pulse;
  logic sample_valid;
  logic LED2;

  int total;
  int bad;

  proximity_sequencer #(
    .PERIOD  (PERIOD),
    .SETTLE  (SETTLE),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .proximity_out(proximity_out),
    .emitter_en   (emitter_en),
    .proximity    (proximity),
    .detect_pulse (detect_pulse),
    .release_pulse(release_pulse),
    .sample_valid (sample_valid),
    .LED2         (LED2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: position within the period, sample slot, run length.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    bit active;   // sequence running
    int pos;      // cycle index inside the current period (0 = first burst cycle)
    bit s1;       // sensor delayed by one edge
    bit s2;       // sensor delayed by two edges (what the sample sees)
    int streak;   // consecutive disagreeing samples
    bit prox;
    bit led;
    bit det;
    bit rel;
    bit sv;
    bit emit;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, bit en, bit raw);
    model_t nxt;
    nxt     = cur;
    nxt.det = 1'b0;
    nxt.rel = 1'b0;
    nxt.sv  = 1'b0;
    nxt.led = cur.prox;
    nxt.s1  = raw;
    nxt.s2  = cur.s1;
    if (!en) begin
      nxt.active = 1'b0;
      nxt.pos    = 0;
      nxt.streak = 0;
    end else if (!cur.active) begin
      nxt.active = 1'b1;
      nxt.pos    = 0;
    end else begin
      if (cur.pos == SETTLE) begin
        nxt.sv = 1'b1;
        nxt.streak = (cur.s2 != cur.prox) ? cur.streak + 1 : 0;
        if (nxt.streak == DEBOUNCE) begin
          nxt.prox   = cur.s2;
          nxt.det    = cur.s2;
          nxt.rel    = ~cur.s2;
          nxt.streak = 0;
        end
      end
      nxt.pos = (cur.pos + 1) % PERIOD;
    end
    nxt.emit = nxt.active && (nxt.pos <= SETTLE);
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, step the model on the edge, compare on the
  // falling edge. Entered and left just after a falling edge.
  task automatic tick(input bit en, input bit s);
    enable        = en;
    proximity_out = s;
    @(posedge clk);
    if (reset_n) m = model_step(m, en, s);
    else         m = '0;
    @(negedge clk);
    check("model", 32'({emitter_en, proximity, detect_pulse, release_pulse, sample_valid, LED2}),
          32'({m.emit, m.prox, m.det, m.rel, m.sv, m.led}));
    check("pulse_rules",
          32'({detect_pulse & release_pulse, (detect_pulse | release_pulse) & ~sample_valid}), 0);
  endtask

  // Runs enabled with sensor s until sample_valid is seen (bounded).
  task automatic run_to_sv(input bit s, output int n, output int emits);
    n     = 0;
    emits = 0;
    do begin
      tick(1'b1, s);
      n++;
      if (emitter_en) emits++;
    end while (!sample_valid && n < 30);
    check("sv_seen", 32'(sample_valid), 1);
  endtask

  typedef struct packed {
    bit sensor;
    bit exp_prox;
    bit exp_det;
    bit exp_rel;
  } vec_t;

  vec_t tab[11];

  initial begin
    int  n;
    int  emits;
    int  exp_n;
    bit  s_next;
    bit  s_r;
    bit  en_r;

    // Per-sample vectors, starting from proximity=0 after reset.
    tab[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};  // streak 1
    tab[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};  // streak 2 -> detect
    tab[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};  // streak 1
    tab[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};  // agrees -> cleared
    tab[5]  = '{1'b0, 1'b1, 1'b0, 1'b0};  // streak 1
    tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b1};  // streak 2 -> release
    tab[7]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};  // agrees -> cleared
    tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tab[10] = '{1'b1, 1'b1, 1'b1, 1'b0};

    total         = 0;
    bad           = 0;
    m             = '0;
    reset_n       = 1'b1;
    enable        = 1'b0;
    proximity_out = 1'b0;

    // Reset state.
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          32'({emitter_en, proximity, detect_pulse, release_pulse, sample_valid, LED2}), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Idle with enable low: nothing moves.
    for (int k = 0; k < 3; k++) tick(1'b0, tab[0].sensor);
    check("idle_emitter", 32'(emitter_en), 0);

    // Table-driven sample sequence.
    for (int i = 0; i < 11; i++) begin
      run_to_sv(tab[i].sensor, n, emits);
      exp_n = (i == 0) ? SETTLE + 2 : PERIOD - 1;
      check("tab_interval", n, exp_n);
      check("tab_emitter_cycles", emits, SETTLE + 1);
      check("tab_result", 32'({proximity, detect_pulse, release_pulse}),
            32'({tab[i].exp_prox, tab[i].exp_det, tab[i].exp_rel}));
      s_next = (i < 10) ? tab[i + 1].sensor : tab[i].sensor;
      tick(1'b1, s_next);
      check("tab_after", 32'({detect_pulse, release_pulse, sample_valid, LED2}),
            32'({1'b0, 1'b0, 1'b0, tab[i].exp_prox}));
    end

    // Enable dropped in SETTLE: pending debounce count is lost.
    run_to_sv(1'b0, n, emits);
    check("drop_pre_prox", 32'(proximity), 1);
    n = 0;
    do begin
      tick(1'b1, 1'b0);
      n++;
    end while (!emitter_en && n < 30);
    check("drop_burst_seen", 32'(emitter_en), 1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("drop_emitter_off", 32'(emitter_en), 0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      check("drop_no_sample", 32'({emitter_en, sample_valid}), 0);
    end
    for (int k = 0; k < SETTLE + 1; k++) begin
      tick(1'b1, 1'b0);
      check("reenable_burst", 32'(emitter_en), 1);
    end
    tick(1'b1, 1'b0);
    check("reenable_first_sample", 32'({sample_valid, proximity, release_pulse}), 32'(3'b110));
    run_to_sv(1'b0, n, emits);
    check("reenable_interval", n, PERIOD);
    check("reenable_release", 32'({proximity, release_pulse}), 32'(2'b01));

    // Sensor held high: proximity rises on the 2nd sample, LED2 one later.
    run_to_sv(1'b1, n, emits);
    check("rise_first_sample", 32'({proximity, detect_pulse}), 0);
    run_to_sv(1'b1, n, emits);
    check("rise_second_sample", 32'({proximity, detect_pulse, LED2}), 32'(3'b110));
    tick(1'b1, 1'b1);
    check("rise_pulse_width", 32'({detect_pulse, LED2}), 32'(2'b01));

    // Reset asserted mid-WAIT with proximity=1.
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1);
    check("wait_state_prox", 32'({emitter_en, proximity}), 32'(2'b01));
    #1 reset_n = 1'b0;
    #1;
    check("async_reset",
          32'({emitter_en, proximity, detect_pulse, release_pulse, sample_valid, LED2}), 0);
    m = '0;
    #1 reset_n = 1'b1;
    tick(1'b1, 1'b1);
    check("post_reset_burst", 32'(emitter_en), 1);

    // Glitching sensor, toggling every cycle.
    for (int k = 0; k < 120; k++) tick(1'b1, k[0]);

    // Randomized enable/sensor activity against the model.
    s_r = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      en_r = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 5) == 0) s_r = ~s_r;
      tick(en_r, s_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
